// File: rtl/findmax_fsm.sv
// Streaming maximum finder: scans a valid/ready sample stream and publishes the
// largest sample, the index of its first occurrence and the sample count.

module magComp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             aGtB
);
    assign aGtB = a > b;
endmodule

module findmax_fsm #(
    parameter  int WIDTH  = 8,
    parameter  int MAXLEN = 16,
    localparam int CW     = $clog2(MAXLEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic             busy,
    output logic [WIDTH-1:0] max_out,
    output logic [CW-1:0]    max_idx,
    output logic [CW-1:0]    count,
    output logic             max_valid
);
    typedef enum logic [1:0] {IDLE, FIRST, SCAN, DONE} stateT;

    localparam bit SINGLE_SAMPLE = (MAXLEN == 1);

    stateT            state, nextState;
    logic [WIDTH-1:0] maxReg;
    logic [CW-1:0]    idxReg;
    logic [CW-1:0]    cntReg;
    logic [CW-1:0]    cntNext;
    logic             transfer;
    logic             atLimit;
    logic             aGtB;

    magComp #(.WIDTH(WIDTH)) cmp (
        .a    (din),
        .b    (maxReg),
        .aGtB (aGtB)
    );

    assign transfer = din_valid & din_ready;
    assign cntNext  = cntReg + CW'(1);
    assign atLimit  = (cntNext == CW'(MAXLEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        din_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = FIRST;
                end
            end
            FIRST: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (transfer) begin
                    nextState = (din_last || SINGLE_SAMPLE) ? DONE : SCAN;
                end
            end
            SCAN: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (transfer && (din_last || atLimit)) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Strict greater-than keeps the earlier index when a tie arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            maxReg    <= '0;
            idxReg    <= '0;
            cntReg    <= '0;
            max_out   <= '0;
            max_idx   <= '0;
            count     <= '0;
            max_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        max_valid <= 1'b0;
                        cntReg    <= '0;
                    end
                end
                FIRST: begin
                    if (transfer) begin
                        maxReg <= din;
                        idxReg <= '0;
                        cntReg <= CW'(1);
                    end
                end
                SCAN: begin
                    if (transfer) begin
                        if (aGtB) begin
                            maxReg <= din;
                            idxReg <= cntReg;
                        end
                        cntReg <= cntNext;
                    end
                end
                DONE: begin
                    max_out   <= maxReg;
                    max_idx   <= idxReg;
                    count     <= cntReg;
                    max_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
